dror_validation_scheduler: RTL and testbench
============================================

# dror_validation_scheduler

Sequencer that feeds one DROR/LIOR validation job into the validator core. For each job it fetches the target point from the banked point-cloud RAM, streams every candidate batch of `DISTANCE_MODULES` points into the core, and masks the target's own slot and the out-of-range slots of the last batch. It clears the core's neighbour counter between jobs and returns a single inlier/outlier verdict through a valid/ready handshake. It sits between the frame-level point iterator and the validator core.

## Interface

**Parameters**
- `N`, 16: coordinate width in bits.
- `DISTANCE_MODULES`, 8: lanes per batch. Must be a power of two, ≥2.
- `ADDR_W`, 16: batch address width of the point RAM.
- `CORE_LATENCY`, 2: cycles from `o_cp_valid` to the matching `i_core_inlier` update.

**Ports**
- `i_clock`, in, 1: single clock.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: job request.
- `o_ready`, out, 1: job accept. A job is accepted on a cycle where `i_start & o_ready`.
- `i_target_idx`, in, 2N: point index to validate.
- `i_point_cloud_size`, in, 2N: points in the cloud. Sampled at accept.
- `o_rd_en`, out, 1: RAM read strobe.
- `o_rd_addr`, out, ADDR_W: batch address, equal to point index / `DISTANCE_MODULES`.
- `i_rd_data`, in, 3N·DISTANCE_MODULES: one batch. Lane k is `{z,y,x}`. Read latency is 1 cycle.
- `o_point_x`, `o_point_y`, `o_point_z`, out, N each: held target coordinates.
- `o_cp_x`, `o_cp_y`, `o_cp_z`, out, N·DISTANCE_MODULES each: candidate batch.
- `o_cp_valid`, out, DISTANCE_MODULES: per-lane valid mask. Non-zero only for one cycle per batch.
- `o_core_clear`, out, 1: one-cycle pulse that zeroes the core's neighbour counter.
- `i_core_inlier`, in, 1: core's "threshold reached" flag.
- `o_result_valid`, out, 1: verdict available.
- `i_result_ready`, in, 1: verdict consumed.
- `o_result_inlier`, out, 1: 1 = inlier, 0 = outlier.
- `o_result_err`, out, 1: job was invalid.

## Operation

The FSM states are IDLE, TGT_RD, TGT_CAP, FETCH, DRAIN and RESULT.

- **IDLE**
  - `o_ready`=1.
  - On accept, latch the index and size, then go to TGT_RD.
  - If size==0 or idx≥size, go directly to RESULT with inlier=0 and err=1.
- **TGT_RD**
  - Drive `o_rd_en`=1 and `o_rd_addr`=idx>>log2(DM).
  - Pulse `o_core_clear`.
- **TGT_CAP**
  - Capture lane idx%DM of `i_rd_data` into the target registers.
  - Reset the batch counter b to 0.
- **FETCH**
  - Issue one read per cycle at address b, for b = 0 … B−1, where B = ceil(size/DM).
  - One cycle after each read, present the batch with `o_cp_valid`.
  - In `o_cp_valid`, lane k is 1 iff:
    - global index b·DM+k < size, and
    - global index ≠ idx.
  - After the last issue, go to DRAIN.
- **DRAIN**
  - Count CORE_LATENCY+1 cycles, then go to RESULT.
- **RESULT**
  - Hold `o_result_valid`.
  - On `i_result_ready`, return to IDLE.
  - A new job may be accepted in the cycle after the verdict is consumed; there is no overlap.
- **Verdict latch**
  - A sticky `hit` flag is cleared in TGT_RD.
  - It is set by `i_core_inlier` in any cycle of FETCH or DRAIN.
  - `o_result_inlier` = hit.
- **Boundary cases**
  - size==1 (idx=0): one batch with an all-zero mask, so the verdict is outlier with err=0.
  - Final partial batch: the lanes beyond size are masked.
  - Partial address overflow: a size needing more than 2^ADDR_W batches is flagged err at accept.
- **Reset:** asserting `i_reset` at any time forces IDLE immediately and abandons any in-flight job without a result.
- **Output reset values:**
  - `o_ready`=1.
  - All other outputs 0, including the target registers.

## Timing

- Accept edge = cycle 0. TGT_RD is cycle 1 and TGT_CAP is cycle 2.
- Batch b is read in cycle 3+b and its `o_cp_valid` is in cycle 4+b.
- Without early exit, `o_result_valid` rises in cycle B+CORE_LATENCY+5.
- In an error job, `o_result_valid` rises in cycle 1.
- `o_result_*` are registered and stable while valid is high and ready is low.

## Configuration

- `DROR_EARLY_EXIT_EN` defined: when hit is set during FETCH, stop issuing reads and go straight to RESULT on the next cycle.
  - Batches already in flight are not marked valid.
  - Latency becomes data-dependent.
- `DROR_EARLY_EXIT_EN` undefined: the full cloud is always scanned, giving fixed latency.

## Structure

- **Package `dror_pkg`:**
  - state enum;
  - packed point struct `{z,y,x}`;
  - `ceil_div` function;
  - `clog2`-based lane-index width constant.
- **Sub-module `dror_lane_mask_gen`:** combinational; takes the batch index, size and target index and produces the `o_cp_valid` mask.

## Test plan

- **Full scan, outlier:** DM=8, LAT=2, size=20, idx=5, `i_core_inlier` held 0.
  - Verdict outlier at cycle 10.
  - Masks are 0xDF, 0xFF, 0x0F.
- **Inlier, no early exit:** `i_core_inlier` rises in batch 1.
  - Verdict inlier at cycle 10.
  - All 3 batches issued.
- **Inlier with `DROR_EARLY_EXIT_EN`:** the same stimulus gives inlier at cycle 7.
  - No valid batch is issued after the hit.
- **Error jobs:**
  - idx=20, size=20: err=1 and inlier=0, with valid at cycle 1.
  - size=0: the same response.
- **Backpressure:** `i_result_ready` held low for 5 cycles.
  - The verdict stays stable and `o_ready` stays 0.
  - A next job accepted right after the handshake gets a `o_core_clear` pulse.
- **Reset mid-job:** `i_reset` goes low during FETCH.
  - Outputs take their reset values asynchronously.
  - No `o_result_valid` is produced.

Source files
------------

// File: rtl/dror_pkg.sv
// Shared types and helpers for the DROR/LIOR validation scheduler.
// Optional feature macro used by the top: DROR_EARLY_EXIT_EN.
package dror_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TGT_RD  = 3'd1,
    ST_TGT_CAP = 3'd2,
    ST_FETCH   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_RESULT  = 3'd5
  } state_t;

  // Default geometry: one point is {z,y,x} of COORD_W bits each.
  localparam int unsigned COORD_W    = 16;
  localparam int unsigned DM_DEFAULT = 8;
  localparam int unsigned LANE_W     = $clog2(DM_DEFAULT);

  typedef struct packed {
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

  // Number of batches of size den needed to cover num points.
  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    return (num + den - 64'd1) / den;
  endfunction

endpackage

// File: rtl/dror_lane_mask_gen.sv
// Per-lane valid mask for one candidate batch: a lane is live when its
// global point index lies inside the cloud and is not the target itself.
module dror_lane_mask_gen
  import dror_pkg::*;
#(
  parameter int IDX_W = 32,
  parameter int DM    = 8
) (
  input  logic [IDX_W-1:0] batch_idx,
  input  logic [IDX_W-1:0] size,
  input  logic [IDX_W-1:0] target_idx,
  output logic [DM-1:0]    mask
);

  localparam int LANE_BITS = $clog2(DM);
  localparam int GIDX_W    = IDX_W + LANE_BITS;

  for (genvar k = 0; k < DM; k++) begin : g_lane
    logic [GIDX_W-1:0] gidx;
    assign gidx    = {batch_idx, LANE_BITS'(k)};
    assign mask[k] = (gidx < GIDX_W'(size)) && (gidx != GIDX_W'(target_idx));
  end

endmodule

// File: rtl/dror_validation_scheduler.sv
// Job sequencer in front of the DROR/LIOR validator core: fetches the target
// point, streams every candidate batch with a lane mask, clears the core's
// neighbour counter and returns one inlier/outlier verdict per job.
// Optional feature: define DROR_EARLY_EXIT_EN to stop scanning on the first hit.
module dror_validation_scheduler
  import dror_pkg::*;
#(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 8,
  parameter int ADDR_W           = 16,
  parameter int CORE_LATENCY     = 2
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  output logic                          o_ready,
  input  logic [2*N-1:0]                i_target_idx,
  input  logic [2*N-1:0]                i_point_cloud_size,
  output logic                          o_rd_en,
  output logic [ADDR_W-1:0]             o_rd_addr,
  input  logic [3*N*DISTANCE_MODULES-1:0] i_rd_data,
  output logic [N-1:0]                  o_point_x,
  output logic [N-1:0]                  o_point_y,
  output logic [N-1:0]                  o_point_z,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_x,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_y,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_z,
  output logic [DISTANCE_MODULES-1:0]   o_cp_valid,
  output logic                          o_core_clear,
  input  logic                          i_core_inlier,
  output logic                          o_result_valid,
  input  logic                          i_result_ready,
  output logic                          o_result_inlier,
  output logic                          o_result_err
);

  localparam int DM        = DISTANCE_MODULES;
  localparam int LANE_BITS = $clog2(DM);
  localparam int IDX_W     = 2 * N;
  localparam int DRAIN_W   = $clog2(CORE_LATENCY + 2) + 1;
  // The last batch is presented in the first DRAIN cycle; the core needs
  // CORE_LATENCY+1 further cycles before its flag is final.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(CORE_LATENCY + 1);

`ifdef DROR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, size_q, nbatch_q, b_q, cp_batch_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic                cp_pending_q, hit_q, err_q;
  logic                accept, job_err, cp_live;
  logic [3*N-1:0]      tgt_word;
  logic [DM-1:0]       lane_mask;

  assign accept  = i_start && (state_q == ST_IDLE);
  assign o_ready = (state_q == ST_IDLE);

  // Invalid job: empty cloud, target outside it, or more batches than the RAM can address.
  assign job_err = (i_point_cloud_size == '0) || (i_target_idx >= i_point_cloud_size)
                || (ceil_div(64'(i_point_cloud_size), 64'(DM)) > (64'd1 << ADDR_W));

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and RAM / core-clear strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    o_rd_en      = 1'b0;
    o_rd_addr    = '0;
    o_core_clear = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (i_start) state_d = job_err ? ST_RESULT : ST_TGT_RD;
      ST_TGT_RD: begin
        o_rd_en      = 1'b1;
        o_rd_addr    = ADDR_W'(idx_q >> LANE_BITS);
        o_core_clear = 1'b1;
        state_d      = ST_TGT_CAP;
      end
      ST_TGT_CAP: state_d = ST_FETCH;
      ST_FETCH: begin
        if (EARLY_EXIT && hit_q) begin
          state_d = ST_RESULT;
        end else begin
          o_rd_en   = 1'b1;
          o_rd_addr = ADDR_W'(b_q);
          if (b_q == nbatch_q - 1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:   if ((EARLY_EXIT && hit_q) || (drain_cnt_q == DRAIN_LAST)) state_d = ST_RESULT;
      ST_RESULT:  if (i_result_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pick the target's lane out of the batch returned by the target read.
  always_comb begin
    tgt_word = '0;
    for (int k = 0; k < DM; k++)
      if (idx_q[LANE_BITS-1:0] == LANE_BITS'(k)) tgt_word = i_rd_data[k*3*N +: 3*N];
  end

  // Job registers, batch counter, drain counter and the sticky verdict flag.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idx_q        <= '0;
      size_q       <= '0;
      nbatch_q     <= '0;
      b_q          <= '0;
      cp_batch_q   <= '0;
      cp_pending_q <= 1'b0;
      drain_cnt_q  <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      o_point_x    <= '0;
      o_point_y    <= '0;
      o_point_z    <= '0;
    end else begin
      cp_pending_q <= 1'b0;
      if (accept) begin
        idx_q    <= i_target_idx;
        size_q   <= i_point_cloud_size;
        nbatch_q <= IDX_W'(ceil_div(64'(i_point_cloud_size), 64'(DM)));
        err_q    <= job_err;
        if (job_err) hit_q <= 1'b0;
      end
      if (state_q == ST_TGT_RD) hit_q <= 1'b0;
      if (state_q == ST_TGT_CAP) begin
        o_point_x <= tgt_word[N-1:0];
        o_point_y <= tgt_word[2*N-1:N];
        o_point_z <= tgt_word[3*N-1:2*N];
        b_q       <= '0;
      end
      if ((state_q == ST_FETCH) && o_rd_en) begin
        b_q          <= b_q + 1;
        cp_pending_q <= 1'b1;
        cp_batch_q   <= b_q;
        drain_cnt_q  <= '0;
      end
      if (state_q == ST_DRAIN) drain_cnt_q <= drain_cnt_q + 1;
      if (((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && i_core_inlier) hit_q <= 1'b1;
    end
  end

  // Batch data arrives one cycle after its read; a hit already seen kills it when exiting early.
  assign cp_live = cp_pending_q && !(EARLY_EXIT && hit_q);

  dror_lane_mask_gen #(.IDX_W(IDX_W), .DM(DM)) u_mask (
    .batch_idx  (cp_batch_q),
    .size       (size_q),
    .target_idx (idx_q),
    .mask       (lane_mask)
  );

  assign o_cp_valid = cp_live ? lane_mask : '0;

  for (genvar k = 0; k < DM; k++) begin : g_cp
    assign o_cp_x[k*N +: N] = cp_live ? i_rd_data[k*3*N       +: N] : '0;
    assign o_cp_y[k*N +: N] = cp_live ? i_rd_data[k*3*N + N   +: N] : '0;
    assign o_cp_z[k*N +: N] = cp_live ? i_rd_data[k*3*N + 2*N +: N] : '0;
  end

  assign o_result_valid  = (state_q == ST_RESULT);
  assign o_result_inlier = o_result_valid && hit_q;
  assign o_result_err    = o_result_valid && err_q;

endmodule

// File: tb/tb_dror_validation_scheduler.sv
// Self-checking bench for dror_validation_scheduler: hand table of jobs,
// randomized jobs against a job-level reference model, reset-mid-job sequence.
module tb_dror_validation_scheduler;
  import dror_pkg::*;

  localparam int N = 16, DM = 8, AW = 16, LAT = 2;
`ifdef DROR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                 i_clock, i_reset, i_start, o_ready;
  logic [2*N-1:0]       i_target_idx, i_point_cloud_size;
  logic                 o_rd_en;
  logic [AW-1:0]        o_rd_addr;
  logic [3*N*DM-1:0]    i_rd_data;
  logic [N-1:0]         o_point_x, o_point_y, o_point_z;
  logic [N*DM-1:0]      o_cp_x, o_cp_y, o_cp_z;
  logic [DM-1:0]        o_cp_valid;
  logic                 o_core_clear, i_core_inlier;
  logic                 o_result_valid, i_result_ready, o_result_inlier, o_result_err;

  dror_validation_scheduler #(.N(N), .DISTANCE_MODULES(DM), .ADDR_W(AW), .CORE_LATENCY(LAT)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .o_ready(o_ready),
    .i_target_idx(i_target_idx), .i_point_cloud_size(i_point_cloud_size),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_point_x(o_point_x), .o_point_y(o_point_y), .o_point_z(o_point_z),
    .o_cp_x(o_cp_x), .o_cp_y(o_cp_y), .o_cp_z(o_cp_z), .o_cp_valid(o_cp_valid),
    .o_core_clear(o_core_clear), .i_core_inlier(i_core_inlier),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result_inlier(o_result_inlier), .o_result_err(o_result_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DM-1:0] seen_masks[$];

  // Contents of the point cloud: a distinct, easily derived point per global index.
  function automatic point_t pt_of(input int unsigned g);
    point_t p;
    p.x = COORD_W'(g * 7 + 3);
    p.y = COORD_W'(g ^ 32'h5a5a);
    p.z = COORD_W'(~g);
    return p;
  endfunction

  function automatic logic [3*N*DM-1:0] batch_word(input logic [AW-1:0] a);
    logic [3*N*DM-1:0] w;
    for (int k = 0; k < DM; k++) w[k*3*N +: 3*N] = pt_of(int'(a) * DM + k);
    return w;
  endfunction

  function automatic logic [N*DM-1:0] batch_x(input int unsigned b);
    logic [N*DM-1:0] v;
    for (int k = 0; k < DM; k++) v[k*N +: N] = pt_of(b * DM + k).x;
    return v;
  endfunction

  // Point RAM with one cycle of read latency.
  always @(posedge i_clock) if (o_rd_en) i_rd_data <= batch_word(o_rd_addr);

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Job-level reference: verdict, error flag and verdict cycle from the job parameters.
  task automatic model_job(input int unsigned idx, size, inl,
                           output bit err, output bit inlier, output int unsigned cyc);
    longint unsigned nb;
    int unsigned h;
    nb     = (longint'(size) + DM - 1) / DM;
    err    = (size == 0) || (idx >= size) || (nb > (64'd1 << AW));
    h      = (inl == 0) ? 32'hffff : ((inl < 3) ? 3 : inl);
    inlier = !err && (inl != 0) && (h <= int'(nb) + LAT + 4);
    if (err) cyc = 1;
    else begin
      cyc = int'(nb) + LAT + 5;
      if (EARLY && inlier && (h + 2 < cyc)) cyc = h + 2;
    end
  endtask

  // Runs one job starting at a negedge in IDLE; ends at the negedge after the handshake.
  task automatic run_job(input int unsigned idx, size, inl, hold,
                         input bit e_err, input bit e_inl, input int unsigned e_cyc, input string tag);
    logic [DM-1:0] em [0:63];
    logic [DM-1:0] exp_m;
    int unsigned nb, h;
    point_t tp;
    nb = (size + DM - 1) / DM;
    h  = (inl == 0) ? 32'hffff : ((inl < 3) ? 3 : inl);
    for (int b = 0; b < 64; b++) em[b] = '0;
    if (!e_err)
      for (int unsigned g = 0; g < size; g++)
        if (g != idx) em[g >> LANE_W][g[LANE_W-1:0]] = 1'b1;
    seen_masks.delete();
    tp = pt_of(idx);

    i_target_idx       = 32'(idx);
    i_point_cloud_size = 32'(size);
    i_start            = 1'b1;
    i_core_inlier      = 1'b0;
    check({tag, " ready_idle"}, 128'(o_ready), 128'(1));
    @(posedge i_clock);
    for (int c = 1; c <= int'(e_cyc); c++) begin
      @(negedge i_clock);
      i_start       = 1'b0;
      i_core_inlier = (inl != 0) && (c >= int'(inl));
      exp_m = '0;
      if (c >= 4 && (c - 4) < int'(nb) && (c - 4) < 64 && (!EARLY || c <= int'(h))) exp_m = em[c-4];
      check($sformatf("%s cp_valid c%0d", tag, c), 128'(o_cp_valid), 128'(exp_m));
      if (exp_m != '0) check($sformatf("%s cp_x c%0d", tag, c), 128'(o_cp_x), 128'(batch_x(c - 4)));
      if (o_cp_valid != '0) seen_masks.push_back(o_cp_valid);
      check($sformatf("%s core_clear c%0d", tag, c), 128'(o_core_clear), 128'(!e_err && c == 1));
      if (c == 3 && !e_err) begin
        check({tag, " point_x"}, 128'(o_point_x), 128'(tp.x));
        check({tag, " point_y"}, 128'(o_point_y), 128'(tp.y));
        check({tag, " point_z"}, 128'(o_point_z), 128'(tp.z));
      end
      check($sformatf("%s result_valid c%0d", tag, c), 128'(o_result_valid), 128'(c == int'(e_cyc)));
      check($sformatf("%s ready_busy c%0d", tag, c), 128'(o_ready), 128'(0));
    end
    check({tag, " inlier"}, 128'(o_result_inlier), 128'(e_inl));
    check({tag, " err"}, 128'(o_result_err), 128'(e_err));
    for (int j = 0; j < int'(hold); j++) begin
      @(negedge i_clock);
      check($sformatf("%s hold_valid %0d", tag, j), 128'(o_result_valid), 128'(1));
      check($sformatf("%s hold_inlier %0d", tag, j), 128'(o_result_inlier), 128'(e_inl));
      check($sformatf("%s hold_err %0d", tag, j), 128'(o_result_err), 128'(e_err));
      check($sformatf("%s hold_ready %0d", tag, j), 128'(o_ready), 128'(0));
    end
    i_result_ready = 1'b1;
    @(negedge i_clock);
    i_result_ready = 1'b0;
    i_core_inlier  = 1'b0;
    check({tag, " valid_after_hs"}, 128'(o_result_valid), 128'(0));
    check({tag, " ready_after_hs"}, 128'(o_ready), 128'(1));
  endtask

  typedef struct {
    int unsigned idx, size, inl, hold;
    bit          err, inlier;
    int unsigned cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit          m_err, m_inl;
    int unsigned m_cyc, sz, id, nb, inl;
    bit          seen_valid;

    // idx, size, inlier-from-cycle (0 = never), ready hold, err, inlier, verdict cycle
    vecs[0] = '{5, 20, 0, 0, 1'b0, 1'b0, 10};
    vecs[1] = '{5, 20, 5, 0, 1'b0, 1'b1, EARLY ? 7 : 10};
    vecs[2] = '{20, 20, 0, 0, 1'b1, 1'b0, 1};
    vecs[3] = '{0, 0, 0, 1, 1'b1, 1'b0, 1};
    vecs[4] = '{0, 1, 0, 0, 1'b0, 1'b0, 8};
    vecs[5] = '{3, 8, 0, 5, 1'b0, 1'b0, 8};
    vecs[6] = '{0, 524289, 0, 0, 1'b1, 1'b0, 1};
    vecs[7] = '{23, 24, 0, 2, 1'b0, 1'b0, 10};
    vecs[8] = '{2, 9, 8, 0, 1'b0, 1'b1, 9};
    vecs[9] = '{2, 9, 9, 0, 1'b0, 1'b0, 9};

    i_reset = 1'b0; i_start = 1'b0; i_target_idx = '0; i_point_cloud_size = '0;
    i_core_inlier = 1'b0; i_result_ready = 1'b0;
    #1;
    check("rst ready", 128'(o_ready), 128'(1));
    check("rst rd_en", 128'(o_rd_en), 128'(0));
    check("rst rd_addr", 128'(o_rd_addr), 128'(0));
    check("rst point", 128'({o_point_z, o_point_y, o_point_x}), 128'(0));
    check("rst cp_valid", 128'(o_cp_valid), 128'(0));
    check("rst cp_xyz", 128'(o_cp_x | o_cp_y | o_cp_z), 128'(0));
    check("rst clear", 128'(o_core_clear), 128'(0));
    check("rst result", 128'({o_result_valid, o_result_inlier, o_result_err}), 128'(0));
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].idx, vecs[i].size, vecs[i].inl, vecs[i].hold,
              vecs[i].err, vecs[i].inlier, vecs[i].cyc, $sformatf("vec%0d", i));
      if (i == 0) begin
        check("tp1 nbatches", 128'(seen_masks.size()), 128'(3));
        if (seen_masks.size() == 3) begin
          check("tp1 mask0", 128'(seen_masks[0]), 128'(8'hDF));
          check("tp1 mask1", 128'(seen_masks[1]), 128'(8'hFF));
          check("tp1 mask2", 128'(seen_masks[2]), 128'(8'h0F));
        end
      end
      if (i == 1) check("tp2 nbatches", 128'(seen_masks.size()), 128'(EARLY ? 2 : 3));
    end

    // Randomized jobs against the job-level model.
    for (int r = 0; r < 24; r++) begin
      sz  = $urandom_range(1, 40);
      id  = $urandom_range(0, sz + 1);
      nb  = (sz + DM - 1) / DM;
      inl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, nb + LAT + 8);
      model_job(id, sz, inl, m_err, m_inl, m_cyc);
      run_job(id, sz, inl, $urandom_range(0, 3), m_err, m_inl, m_cyc, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of FETCH: async return to reset values, no verdict.
    i_target_idx = 32'd5; i_point_cloud_size = 32'd20; i_start = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock); i_start = 1'b0;
    repeat (3) @(negedge i_clock);
    check("mid cp_valid before rst", 128'(o_cp_valid), 128'(8'hDF));
    #2 i_reset = 1'b0;
    #1;
    check("mid rst ready", 128'(o_ready), 128'(1));
    check("mid rst rd_en", 128'(o_rd_en), 128'(0));
    check("mid rst rd_addr", 128'(o_rd_addr), 128'(0));
    check("mid rst point", 128'({o_point_z, o_point_y, o_point_x}), 128'(0));
    check("mid rst cp_valid", 128'(o_cp_valid), 128'(0));
    check("mid rst cp_x", 128'(o_cp_x), 128'(0));
    check("mid rst result", 128'({o_result_valid, o_result_inlier, o_result_err}), 128'(0));
    @(negedge i_clock);
    i_reset = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clock);
      seen_valid |= o_result_valid;
    end
    check("mid no result", 128'(seen_valid), 128'(0));
    run_job(7, 13, 0, 1, 1'b0, 1'b0, 9, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
